// File: rtl/mul_div_unit.sv
// Iterative MIPS multiply/divide unit owning the architectural HI/LO registers.
// One radix-2 multiply step or one restoring-divide step per cycle, then a sign-fix cycle.
module mul_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [1:0]       MDCon,
  input  logic [WIDTH-1:0] DataA,
  input  logic [WIDTH-1:0] DataB,
  input  logic             HIWrite,
  input  logic             LOWrite,
  input  logic [WIDTH-1:0] WriteData,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int unsigned W  = WIDTH;
  localparam int unsigned DW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX
  } state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [DW-1:0]   acc_q;
  logic [W-1:0]    b_q;
  logic            is_div_q;
  logic            neg_lo_q;
  logic            neg_hi_q;
  logic            dz_q;
  logic            busy_q;
  logic            done_q;
  logic            divzero_q;
  logic [W-1:0]    hi_q;
  logic [W-1:0]    lo_q;

  logic            signed_op;
  logic [W-1:0]    a_abs;
  logic [W-1:0]    b_abs;
  logic [W:0]      mul_sum;
  logic [W:0]      div_shift;
  logic [W+1:0]    div_diff;
  logic [DW-1:0]   acc_step;
  logic [DW-1:0]   prod_fix;
  logic [W-1:0]    quo_fix;
  logic [W-1:0]    rem_fix;
  logic            unused_diff_bit;

  // Operand magnitudes; signed ops work on absolute values and fix the sign at the end.
  always_comb begin
    signed_op = ~MDCon[0];
    a_abs     = (signed_op && DataA[W-1]) ? (W'(0) - DataA) : DataA;
    b_abs     = (signed_op && DataB[W-1]) ? (W'(0) - DataB) : DataB;
  end

  // Accumulator layout: multiply keeps {partial, multiplier}; divide keeps {remainder, dividend/quotient}.
  always_comb begin
    mul_sum   = {1'b0, acc_q[DW-1:W]} + {1'b0, (acc_q[0] ? b_q : W'(0))};
    div_shift = {acc_q[DW-1:W], acc_q[W-1]};
    div_diff  = {1'b0, div_shift} - {2'b00, b_q};
    acc_step  = acc_q;
    if (!is_div_q) begin
      acc_step = {mul_sum, acc_q[W-1:1]};
    end else if (!div_diff[W+1]) begin
      acc_step = {div_diff[W-1:0], acc_q[W-2:0], 1'b1};
    end else begin
      acc_step = {div_shift[W-1:0], acc_q[W-2:0], 1'b0};
    end
    unused_diff_bit = div_diff[W];
  end

  always_comb begin
    prod_fix = neg_lo_q ? (DW'(0) - acc_q) : acc_q;
    quo_fix  = neg_lo_q ? (W'(0) - acc_q[W-1:0]) : acc_q[W-1:0];
    rem_fix  = neg_hi_q ? (W'(0) - acc_q[DW-1:W]) : acc_q[DW-1:W];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      b_q       <= '0;
      is_div_q  <= 1'b0;
      neg_lo_q  <= 1'b0;
      neg_hi_q  <= 1'b0;
      dz_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      divzero_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      done_q    <= 1'b0;
      divzero_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (Start) begin
            state_q  <= S_CALC;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            is_div_q <= MDCon[1];
            dz_q     <= MDCon[1] && (DataB == W'(0));
            acc_q    <= MDCon[1] ? {W'(0), a_abs} : {W'(0), b_abs};
            b_q      <= MDCon[1] ? b_abs : a_abs;
            neg_lo_q <= signed_op && (DataA[W-1] ^ DataB[W-1]);
            neg_hi_q <= signed_op && MDCon[1] && DataA[W-1];
          end else begin
            if (HIWrite) hi_q <= WriteData;
            if (LOWrite) lo_q <= WriteData;
          end
        end
        S_CALC: begin
          // Divide-by-zero skips the iterations but still spends one cycle here.
          if (dz_q) begin
            state_q <= S_FIX;
          end else begin
            acc_q <= acc_step;
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == CW'(W - 1)) state_q <= S_FIX;
          end
        end
        S_FIX: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          if (dz_q) begin
            divzero_q <= 1'b1;
          end else if (is_div_q) begin
            hi_q <= rem_fix;
            lo_q <= quo_fix;
          end else begin
            hi_q <= prod_fix[DW-1:W];
            lo_q <= prod_fix[W-1:0];
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign Busy    = busy_q;
  assign Done    = done_q;
  assign DivZero = divzero_q;
  assign HI      = hi_q;
  assign LO      = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: stimulus pushes expected HI/LO/DivZero into a queue,
// a monitor pops and compares on every Done pulse.
module tb_mul_div_unit;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        Start;
  logic [1:0]  MDCon;
  logic [31:0] DataA;
  logic [31:0] DataB;
  logic        HIWrite;
  logic        LOWrite;
  logic [31:0] WriteData;
  logic        Busy;
  logic        Done;
  logic        DivZero;
  logic [31:0] HI;
  logic [31:0] LO;

  exp_t        exp_q[$];
  int          pass_cnt = 0;
  int          total_cnt = 0;
  logic [31:0] model_hi = 32'h0;
  logic [31:0] model_lo = 32'h0;

  mul_div_unit #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .Start     (Start),
    .MDCon     (MDCon),
    .DataA     (DataA),
    .DataB     (DataB),
    .HIWrite   (HIWrite),
    .LOWrite   (LOWrite),
    .WriteData (WriteData),
    .Busy      (Busy),
    .Done      (Done),
    .DivZero   (DivZero),
    .HI        (HI),
    .LO        (LO)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, got, exp);
  endtask

  // Monitor: every Done pulse must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (Done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 64'(1), 64'(0));
        end else begin
          e = exp_q.pop_front();
          check("sb_hi", 64'(HI), 64'(e.hi));
          check("sb_lo", 64'(LO), 64'(e.lo));
          check("sb_divzero", 64'(DivZero), 64'(e.dz));
        end
      end
    end
  end

  // mode 0: plain; 1: Start+LOWrite injected mid-busy; 2: HIWrite coincident with Start.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ehi, input logic [31:0] elo, input logic edz,
                       input int elat, input int mode, input string nm);
    int          n;
    int          busy_n;
    logic        hold_ok;
    logic [31:0] phi;
    logic [31:0] plo;
    phi = model_hi;
    plo = model_lo;
    Start = 1'b1;
    MDCon = op;
    DataA = a;
    DataB = b;
    if (mode == 2) begin
      HIWrite   = 1'b1;
      WriteData = 32'h0000BEEF;
    end
    exp_q.push_back('{hi: ehi, lo: elo, dz: edz});
    model_hi = ehi;
    model_lo = elo;
    @(negedge clk);
    Start   = 1'b0;
    HIWrite = 1'b0;
    MDCon   = ~op;
    DataA   = ~a;
    DataB   = ~b;
    n       = 0;
    busy_n  = 0;
    hold_ok = 1'b1;
    while (!Done && n < 60) begin
      if (Busy) busy_n++;
      if (HI !== phi || LO !== plo) hold_ok = 1'b0;
      if (mode == 1 && n == 10) begin
        Start     = 1'b1;
        MDCon     = 2'b11;
        DataA     = 32'd1;
        DataB     = 32'd1;
        LOWrite   = 1'b1;
        WriteData = 32'h0000DEAD;
      end else if (mode == 1 && n == 11) begin
        Start   = 1'b0;
        LOWrite = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    check({nm, "_latency"}, 64'(n), 64'(elat));
    check({nm, "_busy_cycles"}, 64'(busy_n), 64'(elat));
    check({nm, "_hold_while_busy"}, 64'(hold_ok), 64'(1));
    check({nm, "_busy_low_at_done"}, 64'(Busy), 64'(0));
    @(negedge clk);
    check({nm, "_done_divzero_deassert"}, 64'({Done, DivZero}), 64'(0));
  endtask

  initial begin
    reset     = 1'b1;
    Start     = 1'b0;
    MDCon     = 2'b00;
    DataA     = 32'h0;
    DataB     = 32'h0;
    HIWrite   = 1'b0;
    LOWrite   = 1'b0;
    WriteData = 32'h0;
    repeat (2) @(negedge clk);
    check("reset_busy", 64'(Busy), 64'(0));
    check("reset_done", 64'(Done), 64'(0));
    check("reset_divzero", 64'(DivZero), 64'(0));
    check("reset_hi", 64'(HI), 64'(0));
    check("reset_lo", 64'(LO), 64'(0));
    reset = 1'b0;
    @(negedge clk);

    issue(2'b00, 32'hFFFFFFFD, 32'd5,      32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 33, 0, "mult_neg3x5");
    issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 33, 0, "multu_max");
    issue(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, 33, 0, "mult_m1xm1");
    issue(2'b10, 32'hFFFFFFF9, 32'd2,      32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33, 0, "div_m7_2");
    issue(2'b11, 32'd100,      32'd7,      32'd2,        32'd14,       1'b0, 33, 0, "divu_100_7");
    issue(2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 33, 0, "div_ovf");

    // MTHI then MTLO preload.
    HIWrite   = 1'b1;
    WriteData = 32'h11;
    @(negedge clk);
    HIWrite   = 1'b0;
    LOWrite   = 1'b1;
    WriteData = 32'h22;
    @(negedge clk);
    LOWrite   = 1'b0;
    check("mthi", 64'(HI), 64'h11);
    check("mtlo", 64'(LO), 64'h22);
    model_hi = 32'h11;
    model_lo = 32'h22;

    issue(2'b10, 32'd5, 32'd0, 32'h11, 32'h22, 1'b1, 2, 0, "div_by_zero");
    issue(2'b11, 32'd9, 32'd0, 32'h11, 32'h22, 1'b1, 2, 2, "divu_zero_hiwr");
    issue(2'b00, 32'h1234, 32'h10, 32'h0, 32'h00012340, 1'b0, 33, 1, "mult_inject");
    issue(2'b01, 32'd2, 32'd3, 32'h0, 32'd6, 1'b0, 33, 2, "multu_hiwr");

    // Reset in the middle of a MULT discards everything.
    Start = 1'b1;
    MDCon = 2'b00;
    DataA = 32'd3;
    DataB = 32'd4;
    @(negedge clk);
    Start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", 64'(Busy), 64'(0));
    check("abort_done", 64'(Done), 64'(0));
    check("abort_hi", 64'(HI), 64'(0));
    check("abort_lo", 64'(LO), 64'(0));
    model_hi = 32'h0;
    model_lo = 32'h0;
    @(negedge clk);

    issue(2'b00, 32'd6, 32'd7, 32'h0, 32'd42, 1'b0, 33, 0, "mult_6x7");

    repeat (40) @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
